// File: rtl/mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter
//
// Purpose:
//   Shares one external 32s x 12u multiplier (BlackBoxJam_mul_32s_12ns_32_2_1)
//   among NUM_REQ requesters. Operands are granted round-robin, one per cycle.
//   A shadow pipeline of valid bits and requester tags runs alongside the
//   multiplier's ce-gated register stages. Each product is therefore steered
//   back to the requester that issued it. When the owner of the head result
//   is not ready, the whole shared pipeline (multiplier included) is frozen.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous reset, active low
//   req_valid  per-requester operand valid
//   req_ready  per-requester operand accept (one-hot or zero)
//   req_a      packed signed multiplicands, requester i at [32i+31:32i]
//   req_b      packed unsigned multipliers, requester i at [12i+11:12i]
//   rsp_valid  one-hot product valid for the owning requester
//   rsp_ready  per-requester product accept
//   rsp_data   product (shared by all requesters)
//   mul_ce     multiplier clock enable
//   mul_din0   multiplier operand a
//   mul_din1   multiplier operand b
//   mul_dout   multiplier result
//   stall_cnt  saturating count of cycles spent stalled
// -----------------------------------------------------------------------------
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*12-1:0] req_b,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 mul_ce,
    output logic [31:0]          mul_din0,
    output logic [11:0]          mul_din1,
    input  logic [31:0]          mul_dout,
    output logic [CNT_W-1:0]     stall_cnt
);

    // One extra bit lets ptr + offset exceed NUM_REQ-1 before wrapping.
    localparam int CW = ID_W + 1;

    logic [ID_W-1:0]              ptr_q, ptr_d;
    logic [MUL_LAT-1:0]           vld_q, vld_d;
    logic [MUL_LAT-1:0][ID_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

    logic                         head_valid;
    logic [ID_W-1:0]              head_tag;
    logic                         stall;
    logic                         grant_valid;
    logic [ID_W-1:0]              grant_idx;
    logic                         accept;
    logic [CW-1:0]                cand;

    // Head of the shadow pipeline and response steering. The stall test uses
    // the steered one-hot vector so no variable-width index into rsp_ready is
    // needed.
    always_comb begin
        head_valid = vld_q[MUL_LAT-1];
        head_tag   = tag_q[MUL_LAT-1];
        rsp_valid  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = head_valid && (head_tag == ID_W'(i));
        end
        stall    = head_valid && !(|(rsp_valid & rsp_ready));
        // Holding ce low during reset keeps the multiplier and grant quiet.
        mul_ce   = reset_n && !stall;
        rsp_data = mul_dout;
    end

    // Round-robin search starting just after the last winner. No grant is
    // offered while the pipeline is frozen or in reset (mul_ce low).
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (mul_ce) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = {1'b0, ptr_q} + CW'(k);
                if (cand >= CW'(NUM_REQ)) begin
                    cand = cand - CW'(NUM_REQ);
                end
                if (!grant_valid && req_valid[cand[ID_W-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand[ID_W-1:0];
                end
            end
        end
    end

    // Operand mux and one-hot ready. With no winner the operands are zero.
    always_comb begin
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && (grant_idx == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                mul_din0     = req_a[32*i +: 32];
                mul_din1     = req_b[12*i +: 12];
            end
        end
        accept = |(req_valid & req_ready);
    end

    // Next-state: the shadow pipeline shifts only with ce so it stays in
    // lockstep with the multiplier registers; a bubble enters when nothing
    // is accepted.
    always_comb begin
        ptr_d       = ptr_q;
        vld_d       = vld_q;
        tag_d       = tag_q;
        stall_cnt_d = stall_cnt_q;
        if (mul_ce) begin
            for (int s = MUL_LAT - 1; s > 0; s--) begin
                vld_d[s] = vld_q[s-1];
                tag_d[s] = tag_q[s-1];
            end
            vld_d[0] = accept;
            tag_d[0] = accept ? grant_idx : '0;
        end
        if (accept) begin
            ptr_d = grant_idx;
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Pointer resets to the last requester so requester 0 is searched first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            vld_q       <= '0;
            tag_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            vld_q       <= vld_d;
            tag_q       <= tag_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one BlackBoxJam_mul_32s_12ns_32_2_1 multiplier among NUM_REQ requesters.
- The multiplier computes a 32-bit signed × 12-bit unsigned product, truncates it to 32 bits, registers the output once and gates the register with ce.
- This block grants the multiplier round-robin, drives its din0/din1/ce, and tracks the requester ID of every in-flight operand pair.
- It returns each product to the owning requester over a valid/ready response channel and stalls the shared pipeline on backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; equals clog2(NUM_REQ).
- MUL_LAT, 1, number of ce-gated register stages in the multiplier (dout valid MUL_LAT enabled cycles after the operands).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous reset, active low.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester operand accept, one-hot or zero.
- req_a  in  NUM_REQ*32  signed multiplicands; requester i occupies bits [32i+31:32i].
- req_b  in  NUM_REQ*12  unsigned multipliers; requester i occupies bits [12i+11:12i].
- rsp_valid  out  NUM_REQ  one-hot product valid for the owning requester.
- rsp_ready  in  NUM_REQ  per-requester product accept.
- rsp_data  out  32  product, shared by all requesters.
- mul_ce  out  1  multiplier clock enable.
- mul_din0  out  32  multiplier operand a.
- mul_din1  out  12  multiplier operand b.
- mul_dout  in  32  multiplier result.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset is asynchronous. While reset_n=0:
  - all pipeline valid bits and tags clear;
  - round-robin pointer is set to NUM_REQ-1, so requester 0 has first priority;
  - stall_cnt is 0;
  - req_ready, rsp_valid and mul_ce are 0;
  - mul_din0 and mul_din1 are 0.
- Shadow pipeline: vld[0..MUL_LAT-1] and tag[0..MUL_LAT-1] (ID_W bits each). The pipeline shifts only when mul_ce=1, in lockstep with the multiplier registers.
- Head entry: head_valid = vld[MUL_LAT-1] and head_tag = tag[MUL_LAT-1].
  - rsp_valid[head_tag] = head_valid; all other rsp_valid bits are 0.
  - rsp_data = mul_dout (combinational pass-through).
- Stall condition: stall = head_valid & ~rsp_ready[head_tag]. Then mul_ce = ~stall.
  - While stalled, the multiplier and shadow pipeline hold, so mul_dout and rsp_data stay stable until accepted.
  - Bubbles advance with ce=1 whenever there is no stall.
- Grant:
  - Only when no stall: select the first requester with req_valid=1, searching from (ptr+1) mod NUM_REQ upward with wrap.
  - req_ready is one-hot on the winner and 0 when stalled or when no request is present.
  - req_ready is combinational from registered state and req_valid, never from rsp_ready of a different cycle.
  - mul_din0/mul_din1 carry the winner's req_a/req_b. When there is no grant they are 0 and vld[0] shifts in 0.
- Accept: a request is accepted when req_valid & req_ready. On accept, ptr updates to the winner index, vld[0] is set to 1 and tag[0] to the winner index. ptr is unchanged when there is no accept.
- Latency: operands accepted in cycle T appear on rsp_valid/rsp_data in cycle T+MUL_LAT if no stall intervenes; each stalled cycle adds one.
- Throughput: one accept per cycle sustained, with a full result drained in the same cycle a new operand enters.
- Arithmetic: product = low 32 bits of signed(a) × zero-extended(b). No saturation.
- stall_cnt increments on every cycle with stall=1 and saturates at 2^CNT_W-1.
- A requester may hold req_valid while ungranted. The block imposes no ordering between requesters; a single requester's results return in issue order.
- A reset mid-operation discards all in-flight products; no rsp_valid pulses after reset_n deasserts until a new accept occurs.

Test Plan:
1. Single requester 1: a=-3, b=100 accepted at T, rsp_ready=1 → rsp_valid=4'b0010 at T+1, rsp_data=0xFFFFFED4 (-300).
2. Requesters 0–3 all valid continuously, always ready → grants 0,1,2,3,0,… one per cycle, and each rsp_valid matches the owner one cycle later.
3. Truncation: a=0x7FFFFFFF, b=4095 → rsp_data=0x7FFFF001. Also a=0x80000000, b=1 → rsp_data=0x80000000.
4. Backpressure: result for requester 2 pending with rsp_ready[2]=0 for 3 cycles → mul_ce=0, all req_ready=0, rsp_data stable for 3 cycles, stall_cnt=3. Raise rsp_ready[2] → drains and grants resume the same cycle.
5. Stall saturation: CNT_W=4 with 20 stalled cycles → stall_cnt holds at 15.
6. Reset mid-flight: accept at T, drop reset_n at T+1 before the response is taken → rsp_valid=0 and req_ready=0 immediately. After release, no spurious response and requester 0 wins first.
